alu_seq: RTL and testbench

- Registered 4-operation ALU.
- Two WIDTH-bit operands are combined per a 2-bit opcode. The result is captured into a 2*WIDTH-bit output register on each rising clock edge.
- Used as a small datapath leaf: the result is valid one cycle after the operands and opcode are applied.

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_comb.sv | 41 ++++
 rtl/alu_seq.sv | 59 +++++
 tb/tb_alu_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the registered ALU: opcode encodings and default operand width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: zero-extends A/B to 2*WIDTH bits and applies the selected operation.
// Optional flags (zero, borrow) are built when ALU_SEQ_FLAGS_EN is defined.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         opcode,
`ifdef ALU_SEQ_FLAGS_EN
  output logic               zero,
  output logic               borrow,
`endif
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;

  assign a_ext = {{WIDTH{1'b0}}, a};
  assign b_ext = {{WIDTH{1'b0}}, b};

  always_comb begin
    // NOTE: result gets a value on every path (default branch included) so no latch is inferred.
    result = '0;
    unique case (opcode)
      OP_ADD:  result = a_ext + b_ext;
      OP_OR:   result = a_ext | b_ext;
      OP_SUB:  result = a_ext - b_ext;   // wraps modulo 2^(2*WIDTH) when b > a
      OP_XOR:  result = a_ext ^ b_ext;
      default: result = '0;
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  assign zero   = (result == '0);
  assign borrow = (opcode == OP_SUB) && (b > a);
`endif

endmodule

// File: rtl/alu_seq.sv
// Registered 4-operation ALU: result appears one clock after operands/opcode are sampled.
// Define ALU_SEQ_FLAGS_EN to add registered zero and borrow flag outputs.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         opcode,
`ifdef ALU_SEQ_FLAGS_EN
  output logic               zero,
  output logic               borrow,
`endif
  output logic [2*WIDTH-1:0] out
);

  logic [2*WIDTH-1:0] result;
`ifdef ALU_SEQ_FLAGS_EN
  logic zero_next;
  logic borrow_next;
`endif

  alu_comb #(.WIDTH(WIDTH)) u_core (
    .a      (A),
    .b      (B),
    .opcode (opcode),
`ifdef ALU_SEQ_FLAGS_EN
    .zero   (zero_next),
    .borrow (borrow_next),
`endif
    .result (result)
  );

  // rst is active-low and asynchronous: out clears immediately, independent of clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else begin
      // NOTE: non-blocking assignment so every register samples pre-edge values.
      out <= result;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero   <= 1'b0;
      borrow <= 1'b0;
    end else begin
      zero   <= zero_next;
      borrow <= borrow_next;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random self-checking bench for alu_seq (WIDTH=4); flag checks compile in with ALU_SEQ_FLAGS_EN.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [1:0]     opcode = 2'b00;
  logic [2*W-1:0] out;
`ifdef ALU_SEQ_FLAGS_EN
  logic zero;
  logic borrow;
`endif

  int vectors = 0;
  int miscompares = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .opcode (opcode),
`ifdef ALU_SEQ_FLAGS_EN
    .zero   (zero),
    .borrow (borrow),
`endif
    .out    (out)
  );

  always #5 clk = ~clk;

  // Independent reference: plain integer arithmetic truncated to 8 bits.
  function automatic logic [7:0] ref_alu(input int a, input int b, input logic [1:0] op);
    int r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a | b;
      2'b10:   r = a - b + 256;
      default: r = a ^ b;
    endcase
    return 8'(r % 256);
  endfunction

  // Apply inputs on the falling edge, then wait until just after the capturing rising edge.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    @(negedge clk);
    A = a;
    B = b;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    A = 4'd5;
    B = 4'd5;
    opcode = OP_ADD;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (out !== 8'h00) begin
      $display("FAIL reset_immediate: out=%h expected=%h", out, 8'h00);
      miscompares++;
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out !== 8'h00) begin
      $display("FAIL reset_held: out=%h expected=%h", out, 8'h00);
      miscompares++;
    end
`ifdef ALU_SEQ_FLAGS_EN
    vectors++;
    if (zero !== 1'b0 || borrow !== 1'b0) begin
      $display("FAIL reset_flags: zero=%b borrow=%b expected=0 0", zero, borrow);
      miscompares++;
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out !== 8'd10) begin
      $display("FAIL reset_release: out=%h expected=%h", out, 8'd10);
      miscompares++;
    end
  endtask

  task automatic test_add();
    drive(4'd15, 4'd15, OP_ADD);
    vectors++;
    if (out !== 8'd30) begin
      $display("FAIL add_max: out=%h expected=%h", out, 8'd30);
      miscompares++;
    end
    drive(4'd7, 4'd8, OP_ADD);
    vectors++;
    if (out !== 8'd15) begin
      $display("FAIL add_7_8: out=%h expected=%h", out, 8'd15);
      miscompares++;
    end
  endtask

  task automatic test_logic();
    drive(4'b1010, 4'b0110, OP_OR);
    vectors++;
    if (out !== 8'h0E) begin
      $display("FAIL or: out=%h expected=%h", out, 8'h0E);
      miscompares++;
    end
    drive(4'b1010, 4'b0110, OP_XOR);
    vectors++;
    if (out !== 8'h0C) begin
      $display("FAIL xor: out=%h expected=%h", out, 8'h0C);
      miscompares++;
    end
  endtask

  task automatic test_sub();
    drive(4'd9, 4'd4, OP_SUB);
    vectors++;
    if (out !== 8'd5) begin
      $display("FAIL sub_9_4: out=%h expected=%h", out, 8'd5);
      miscompares++;
    end
    drive(4'd3, 4'd5, OP_SUB);
    vectors++;
    if (out !== 8'hFE) begin
      $display("FAIL sub_wrap: out=%h expected=%h", out, 8'hFE);
      miscompares++;
    end
`ifdef ALU_SEQ_FLAGS_EN
    vectors++;
    if (borrow !== 1'b1 || zero !== 1'b0) begin
      $display("FAIL sub_wrap_flags: zero=%b borrow=%b expected=0 1", zero, borrow);
      miscompares++;
    end
`endif
    drive(4'd6, 4'd6, OP_SUB);
    vectors++;
    if (out !== 8'h00) begin
      $display("FAIL sub_equal: out=%h expected=%h", out, 8'h00);
      miscompares++;
    end
`ifdef ALU_SEQ_FLAGS_EN
    vectors++;
    if (zero !== 1'b1 || borrow !== 1'b0) begin
      $display("FAIL sub_equal_flags: zero=%b borrow=%b expected=1 0", zero, borrow);
      miscompares++;
    end
`endif
  endtask

  task automatic test_latency_and_async_reset();
    drive(4'd15, 4'd15, OP_ADD);
    #2;
    A = 4'd1;
    B = 4'd2;
    opcode = OP_SUB;
    #1;
    vectors++;
    if (out !== 8'd30) begin
      $display("FAIL hold_after_change: out=%h expected=%h", out, 8'd30);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (out !== 8'd30) begin
      $display("FAIL hold_at_negedge: out=%h expected=%h", out, 8'd30);
      miscompares++;
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (out !== 8'h00) begin
      $display("FAIL midcycle_reset: out=%h expected=%h", out, 8'h00);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out !== 8'hFF) begin
      $display("FAIL first_after_reset: out=%h expected=%h", out, 8'hFF);
      miscompares++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [7:0]   exp;
    for (int i = 0; i < 100; i++) begin
      a  = W'($urandom_range(0, 15));
      b  = W'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      exp = ref_alu(int'(a), int'(b), op);
      drive(a, b, op);
      vectors++;
      if (out !== exp) begin
        $display("FAIL random[%0d] a=%0d b=%0d op=%b: out=%h expected=%h", i, a, b, op, out, exp);
        miscompares++;
      end
`ifdef ALU_SEQ_FLAGS_EN
      vectors++;
      if (zero !== (exp == 8'h00) || borrow !== (op == 2'b10 && b > a)) begin
        $display("FAIL random_flags[%0d]: zero=%b borrow=%b expected=%b %b",
                 i, zero, borrow, (exp == 8'h00), (op == 2'b10 && b > a));
        miscompares++;
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic();
    test_sub();
    test_latency_and_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
